// File: rtl/uart_frame_tx_pkg.sv
// Shared UART types and helpers for the transmit and receive framers.
package uart_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Clocks per serial bit; integer divide, truncating any remainder.
   function automatic int unsigned calc_clks_per_bit(input int unsigned freq,
                                                     input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// TX FIFO read port (first-word-fall-through) between fifo_tx and the framer.
interface uart_frame_tx_if #(
   parameter int unsigned DataLength = 8
);
   logic [DataLength-1:0] tx_fifo_data;
   logic                  tx_fifo_empty;
   logic                  tx_fifo_read_en;

   modport master (
      output tx_fifo_data,
      output tx_fifo_empty,
      input  tx_fifo_read_en
   );

   modport slave (
      input  tx_fifo_data,
      input  tx_fifo_empty,
      output tx_fifo_read_en
   );
endinterface

// File: rtl/uart_frame_tx_baud_tick.sv
// Bit-period timer: restarts on start, flags the last clock of every bit period.
module uart_frame_tx_baud_tick #(
   parameter int unsigned ClksPerBit = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic start,
   output logic bit_end_c
);
   localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

   logic [CntW-1:0] cnt;

   // Wrapping counter, re-aligned to the frame on each start pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (start || (cnt == CntMax)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CntW'(1);
      end
   end

   assign bit_end_c = (cnt == CntMax);
endmodule

// File: rtl/uart_frame_tx.sv
// Transmit-side UART framer: pops bytes from the TX FIFO and serialises them
// as start / data (LSB first) / optional parity / stop bits on o_tx.
module uart_frame_tx
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned DataLength      = 8,
   parameter int unsigned BaudRate        = 115200,
   parameter int unsigned SystemClockFreq = 50_000_000,
   parameter bit          Parity          = 1'b0,
   parameter bit          ParityEven      = 1'b0,
   parameter int unsigned StopBits        = 1,
   parameter bit          FlowControl     = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   uart_frame_tx_if.slave fifo_if,
   input  logic           i_cts,
   output logic           o_tx,
   output logic           o_busy
);
   localparam int unsigned ClksPerBit = calc_clks_per_bit(SystemClockFreq, BaudRate);
   localparam int unsigned IdxW       = $clog2(DataLength);

   if (ClksPerBit < 2) begin : g_bad_clks
      $error("uart_frame_tx: ClksPerBit must be at least 2");
   end
   if ((DataLength < 5) || (DataLength > 9)) begin : g_bad_len
      $error("uart_frame_tx: DataLength must be 5..9");
   end
   if ((StopBits < 1) || (StopBits > 2)) begin : g_bad_stop
      $error("uart_frame_tx: StopBits must be 1 or 2");
   end

   tx_state_e             state;
   logic [DataLength-1:0] shift_q;
   logic                  par_q;
   logic [IdxW-1:0]       bit_idx;
   logic                  stop_idx;
   logic [1:0]            cts_sync_q;
   logic                  cts_s;
   logic                  pop_c;
   logic                  bit_end_c;

   // Two-flop synchroniser for the asynchronous CTS input.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cts_sync_q <= 2'b11;
      end else begin
         cts_sync_q <= {cts_sync_q[0], i_cts};
      end
   end

   assign cts_s = FlowControl ? cts_sync_q[1] : 1'b1;
   assign pop_c = (state == IDLE) && !fifo_if.tx_fifo_empty && cts_s;

   uart_frame_tx_baud_tick #(
      .ClksPerBit (ClksPerBit)
   ) u_baud_tick (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .start     (pop_c),
      .bit_end_c (bit_end_c)
   );

   // Frame FSM; o_tx is registered from the current state, so the line trails
   // the state by one clock and the start bit begins the edge after the pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state                   <= IDLE;
         shift_q                 <= '0;
         par_q                   <= 1'b0;
         bit_idx                 <= '0;
         stop_idx                <= 1'b0;
         o_tx                    <= 1'b1;
         o_busy                  <= 1'b0;
         fifo_if.tx_fifo_read_en <= 1'b0;
      end else begin
         fifo_if.tx_fifo_read_en <= 1'b0;
         o_busy                  <= (state != IDLE) || pop_c;
         unique case (state)
            IDLE: begin
               o_tx <= 1'b1;
               if (pop_c) begin
                  fifo_if.tx_fifo_read_en <= 1'b1;
                  shift_q  <= fifo_if.tx_fifo_data;
                  par_q    <= ParityEven ? (^fifo_if.tx_fifo_data) : (~^fifo_if.tx_fifo_data);
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               o_tx <= 1'b0;
               if (bit_end_c) begin
                  state <= DATA;
               end
            end
            DATA: begin
               o_tx <= shift_q[0];
               if (bit_end_c) begin
                  shift_q <= shift_q >> 1;
                  bit_idx <= bit_idx + IdxW'(1);
                  if (bit_idx == IdxW'(DataLength - 1)) begin
                     state <= Parity ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               o_tx <= par_q;
               if (bit_end_c) begin
                  state <= STOP;
               end
            end
            STOP: begin
               o_tx <= 1'b1;
               if (bit_end_c) begin
                  if (stop_idx == 1'(StopBits - 1)) begin
                     state <= IDLE;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            default: begin
               o_tx  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at ClksPerBit=10.
// Instances: 0 = 8N1 with flow control, 1 = 8E1, 2 = 8O1, 3 = 8N2.
module tb_uart_frame_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cts;
   logic [3:0]  tx;
   logic [3:0]  busy;
   logic [3:0]  rd_en;
   logic [3:0]  empty;

   logic [7:0]  mem [4][16];
   int unsigned wp [4];
   int unsigned rp [4];
   int unsigned pop_cnt [4];
   int unsigned last_pop [4];
   int unsigned gap [4];
   int unsigned empty_pops;
   int unsigned cyc;

   int unsigned n_checks;
   int unsigned n_fail;
   int unsigned last_wait;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_frame_tx_if #(.DataLength(8)) fif ();

      assign fif.tx_fifo_empty = (wp[g] == rp[g]);
      assign fif.tx_fifo_data  = mem[g][rp[g][3:0]];
      assign rd_en[g]          = fif.tx_fifo_read_en;
      assign empty[g]          = fif.tx_fifo_empty;

      uart_frame_tx #(
         .DataLength      (8),
         .BaudRate        (100_000),
         .SystemClockFreq (1_000_000),
         .Parity          ((g == 1) || (g == 2)),
         .ParityEven      (g == 1),
         .StopBits        ((g == 3) ? 2 : 1),
         .FlowControl     (g == 0)
      ) u_dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .fifo_if (fif),
         .i_cts   (cts),
         .o_tx    (tx[g]),
         .o_busy  (busy[g])
      );
   end

   // FIFO model pop side plus pop bookkeeping.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         if (rd_en[i]) begin
            if (empty[i]) empty_pops <= empty_pops + 1;
            else          rp[i] <= rp[i] + 1;
            pop_cnt[i]  <= pop_cnt[i] + 1;
            gap[i]      <= cyc - last_pop[i];
            last_pop[i] <= cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d);
      mem[i][wp[i][3:0]] = d;
      wp[i] = wp[i] + 1;
   endtask

   // Waits for the start bit, then checks every 10-clock bit window against
   // exp (bit k = k-th bit on the line), busy at the frame end, and decodes
   // the data byte from mid-bit samples.
   task automatic check_frame(input int i, input string tag, input logic [15:0] exp,
                              input int nbits, input bit next_idle,
                              output logic [7:0] dec);
      logic [159:0] w;
      int           n;
      n   = 0;
      dec = 8'h00;
      while (tx[i] !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (tx[i] !== 1'b0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      last_wait = n;
      w = '0;
      for (int s = 0; s < nbits * 10; s++) begin
         w[s] = tx[i];
         if (s != nbits * 10 - 1) @(negedge clk);
      end
      for (int k = 0; k < nbits; k++) begin
         check($sformatf("%s_bit%0d", tag, k), 32'(w[k*10 +: 10]),
               exp[k] ? 32'h3FF : 32'h000);
      end
      for (int k = 0; k < 8; k++) dec[k] = w[(k + 1) * 10 + 5];
      check({tag, "_busy_last"}, 32'(busy[i]), 32'd1);
      @(negedge clk);
      check({tag, "_tx_after"}, 32'(tx[i]), 32'd1);
      check({tag, "_busy_after"}, 32'(busy[i]), next_idle ? 32'd0 : 32'd1);
   endtask

   initial begin
      int unsigned bad;
      int unsigned pc;
      int          n;
      logic [7:0]  dec;

      n_checks   = 0;
      n_fail     = 0;
      empty_pops = 0;
      for (int i = 0; i < 4; i++) wp[i] = 0;
      rst_n = 1'b0;
      cts   = 1'b1;

      // Reset state
      repeat (5) @(negedge clk);
      check("rst_tx", 32'(tx), 32'hF);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rd_en", 32'(rd_en), 32'h0);

      // Idle with empty FIFOs for 1000 clocks
      rst_n = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 4'hF || busy !== 4'h0 || rd_en !== 4'h0) bad++;
      end
      check("idle_1000", bad, 32'd0);
      check("idle_no_pop", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 32'd0);

      // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
      pc = pop_cnt[0];
      push(0, 8'hA5);
      check_frame(0, "8n1", 16'b11_0100_1010, 10, 1'b1, dec);
      check("8n1_pops", pop_cnt[0] - pc, 32'd1);
      check("8n1_dec", 32'(dec), 32'hA5);

      // Parity on 0x07: even -> 1, odd -> 0; 110-clock frame
      push(1, 8'h07);
      check_frame(1, "par_even", 16'b110_0000_1110, 11, 1'b1, dec);
      push(2, 8'h07);
      check_frame(2, "par_odd", 16'b100_0000_1110, 11, 1'b1, dec);

      // Back-to-back 0x00, 0xFF, 0x55: pops 101 clocks apart
      pc = pop_cnt[0];
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h55);
      check_frame(0, "b2b0", 16'b10_0000_0000, 10, 1'b0, dec);
      check("b2b0_dec", 32'(dec), 32'h00);
      check_frame(0, "b2b1", 16'b11_1111_1110, 10, 1'b0, dec);
      check("b2b1_dec", 32'(dec), 32'hFF);
      check("b2b1_gap", gap[0], 32'd101);
      check("b2b1_stop_ext", last_wait, 32'd1);
      check_frame(0, "b2b2", 16'b10_1010_1010, 10, 1'b1, dec);
      check("b2b2_dec", 32'(dec), 32'h55);
      check("b2b2_gap", gap[0], 32'd101);
      check("b2b2_stop_ext", last_wait, 32'd1);
      check("b2b_pops", pop_cnt[0] - pc, 32'd3);

      // CTS flow control
      cts = 1'b0;
      repeat (5) @(negedge clk);
      pc = pop_cnt[0];
      push(0, 8'h3C);
      push(0, 8'hC3);
      repeat (20) @(negedge clk);
      check("cts_hold_pops", pop_cnt[0] - pc, 32'd0);
      check("cts_hold_tx", 32'(tx[0]), 32'd1);
      cts = 1'b1;
      n = 0;
      while (rd_en[0] !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("cts_pop_latency_le3", 32'((n >= 1) && (n <= 3)), 32'd1);
      cts = 1'b0;
      check_frame(0, "cts_frame", 16'b10_0111_1000, 10, 1'b1, dec);
      check("cts_frame_dec", 32'(dec), 32'h3C);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx[0] !== 1'b1 || rd_en[0] !== 1'b0) bad++;
      end
      check("cts_next_held", bad, 32'd0);
      check("cts_held_pops", pop_cnt[0] - pc, 32'd1);
      cts = 1'b1;
      check_frame(0, "cts_release", 16'b11_1000_0110, 10, 1'b1, dec);
      check("cts_release_dec", 32'(dec), 32'hC3);

      // Reset during data bit 4 on the 2-stop-bit instance
      push(3, 8'h86);
      push(3, 8'h5A);
      n = 0;
      while (tx[3] !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_start_seen", 32'(tx[3]), 32'd0);
      repeat (53) @(negedge clk);
      check("mid_bit4_low", 32'(tx[3]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx[3]), 32'd1);
      check("mid_rst_busy", 32'(busy[3]), 32'd0);
      repeat (3) @(negedge clk);
      check("mid_rst_hold_tx", 32'(tx[3]), 32'd1);
      rst_n = 1'b1;
      check_frame(3, "rst_resume", 16'b111_0101_1010_0, 11, 1'b1, dec);
      check("rst_resume_dec", 32'(dec), 32'h5A);

      // Final bookkeeping
      repeat (5) @(negedge clk);
      check("no_empty_pops", empty_pops, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drained%0d", i), wp[i] - rp[i], 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
